// File: rtl/alu_exec_ctrl_if.sv
// Request/result bundle between ID/EX operand latch, the ALU execute stage and EX/MEM.
// Latency: none, wires only.
// Backpressure: in_ready / out_ready carry the stall in each direction.
interface alu_exec_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       aluop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       select;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, aluop, funct, a, b, out_ready,
        input  in_ready, out_valid, select, result, result_hi, zero, illegal, busy
    );

    modport slave (
        input  in_valid, aluop, funct, a, b, out_ready,
        output in_ready, out_valid, select, result, result_hi, zero, illegal, busy
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU control decode + execute with registered result and iterative shift-add MULTU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 edges for MULTU.
// Backpressure: in_ready drops while multiplying or while an unconsumed result is held.
module alu_exec_ctrl #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_exec_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_MUL = 3'b011;
    localparam logic [2:0] SEL_NOR = 3'b100;
    localparam logic [2:0] SEL_ILL = 3'b101;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, acc_nxt, a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2:0]         dec_sel;
    logic               dec_ill, dec_mul;
    logic [WIDTH-1:0]   alu_res;
    logic               accept, mul_done;

    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign bus.busy     = (state == MUL);
    assign accept       = bus.in_valid && bus.in_ready;
    // Last shift-add step: its partial sum is the finished product.
    assign mul_done     = (state == MUL) && (cnt == CNT_W'(1));
    assign acc_nxt      = b_sh[0] ? acc + a_sh : acc;

    // Decode aluop/funct into the select code; anything unknown is the illegal path.
    always_comb begin
        dec_sel = SEL_ILL;
        dec_ill = 1'b1;
        dec_mul = 1'b0;
        case (bus.aluop)
            2'b00: begin dec_sel = SEL_ADD; dec_ill = 1'b0; end
            2'b01: begin dec_sel = SEL_SUB; dec_ill = 1'b0; end
            2'b10: begin
                case (bus.funct)
                    6'b100000: begin dec_sel = SEL_ADD; dec_ill = 1'b0; end
                    6'b100010: begin dec_sel = SEL_SUB; dec_ill = 1'b0; end
                    6'b100100: begin dec_sel = SEL_AND; dec_ill = 1'b0; end
                    6'b100101: begin dec_sel = SEL_OR;  dec_ill = 1'b0; end
                    6'b101010: begin dec_sel = SEL_SLT; dec_ill = 1'b0; end
                    6'b100111: begin dec_sel = SEL_NOR; dec_ill = 1'b0; end
                    6'b011001: begin
                        if (MUL_EN) begin
                            dec_sel = SEL_MUL;
                            dec_ill = 1'b0;
                            dec_mul = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Single-cycle datapath; illegal and multiply selects yield zero here.
    always_comb begin
        alu_res = '0;
        case (dec_sel)
            SEL_AND: alu_res = bus.a & bus.b;
            SEL_OR:  alu_res = bus.a | bus.b;
            SEL_ADD: alu_res = bus.a + bus.b;
            SEL_SUB: alu_res = bus.a - bus.b;
            SEL_NOR: alu_res = ~(bus.a | bus.b);
            SEL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: enter MUL on a multiply accept, return after the last step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && dec_mul) state_nxt = MUL;
            MUL:     if (mul_done)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add multiplier: latch operands on accept, one partial product per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            acc  <= '0;
            a_sh <= '0;
            b_sh <= '0;
        end else if (state == IDLE) begin
            if (accept && dec_mul) begin
                a_sh <= {{WIDTH{1'b0}}, bus.a};
                b_sh <= bus.b;
                acc  <= '0;
                cnt  <= CNT_W'(WIDTH);
            end
        end else begin
            acc  <= acc_nxt;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // Output slot: loaded by multiply completion or single-cycle accept, freed by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.select    <= 3'b000;
            bus.result    <= '0;
            bus.result_hi <= '0;
            bus.zero      <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (mul_done) begin
            bus.out_valid <= 1'b1;
            bus.select    <= SEL_MUL;
            bus.result    <= acc_nxt[WIDTH-1:0];
            bus.result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
            bus.zero      <= (acc_nxt[WIDTH-1:0] == '0);
            bus.illegal   <= 1'b0;
        end else if (accept && !dec_mul) begin
            bus.out_valid <= 1'b1;
            bus.select    <= dec_sel;
            bus.result    <= alu_res;
            bus.result_hi <= '0;
            bus.zero      <= (alu_res == '0);
            bus.illegal   <= dec_ill;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomised + directed bench for alu_exec_ctrl against a transaction-level model.
// Latency: model tracks the one-cycle slot and the WIDTH-step multiply countdown.
// Backpressure: out_ready is randomised; acceptance follows the model's own slot state.
module tb_alu_exec_ctrl;
    localparam int W = 32;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         ill;
        logic         mul;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.WIDTH(W)) bus ();

    alu_exec_ctrl #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   total = 0;
    int   bad   = 0;
    bit   m_valid = 1'b0;
    int   m_left  = 0;
    rec_t m_rec, m_pend;

    logic [5:0] fn_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                               6'b100111, 6'b011001, 6'b000000, 6'b111111};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // What the stage must produce for one request, straight from the decode table.
    function automatic rec_t ref_op(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [W-1:0] a, input logic [W-1:0] b);
        rec_t r;
        logic [2*W-1:0] p;
        r.sel = 3'b101; r.res = '0; r.hi = '0; r.ill = 1'b1; r.mul = 1'b0;
        if (op == 2'b00) begin r.sel = 3'b010; r.res = a + b; r.ill = 1'b0; end
        else if (op == 2'b01) begin r.sel = 3'b110; r.res = a - b; r.ill = 1'b0; end
        else if (op == 2'b10) begin
            r.ill = 1'b0;
            case (fn)
                6'b100000: begin r.sel = 3'b010; r.res = a + b; end
                6'b100010: begin r.sel = 3'b110; r.res = a - b; end
                6'b100100: begin r.sel = 3'b000; r.res = a & b; end
                6'b100101: begin r.sel = 3'b001; r.res = a | b; end
                6'b101010: begin r.sel = 3'b111; r.res = ($signed(a) < $signed(b)) ? 1 : 0; end
                6'b100111: begin r.sel = 3'b100; r.res = ~(a | b); end
                6'b011001: begin
                    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    r.sel = 3'b011; r.res = p[W-1:0]; r.hi = p[2*W-1:W]; r.mul = 1'b1;
                end
                default: r.ill = 1'b1;
            endcase
        end
        r.zero = (r.res == '0);
        return r;
    endfunction

    task automatic drive(input bit iv, input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit ordy);
        bus.in_valid = iv; bus.aluop = op; bus.funct = fn;
        bus.a = a; bus.b = b; bus.out_ready = ordy;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        bit   m_rdy;
        rec_t r;
        @(posedge clk);
        m_rdy = (m_left == 0) && (!m_valid || bus.out_ready);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_valid = 1'b1; m_rec = m_pend; end
        end else if (bus.in_valid && m_rdy) begin
            r = ref_op(bus.aluop, bus.funct, bus.a, bus.b);
            if (r.mul) begin m_pend = r; m_left = W; m_valid = 1'b0; end
            else begin m_valid = 1'b1; m_rec = r; end
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("busy", 64'(bus.busy), 64'(m_left > 0));
        chk("in_ready", 64'(bus.in_ready), 64'((m_left == 0) && (!m_valid || bus.out_ready)));
        if (m_valid) begin
            chk("select", 64'(bus.select), 64'(m_rec.sel));
            chk("result", 64'(bus.result), 64'(m_rec.res));
            chk("result_hi", 64'(bus.result_hi), 64'(m_rec.hi));
            chk("zero", 64'(bus.zero), 64'(m_rec.zero));
            chk("illegal", 64'(bus.illegal), 64'(m_rec.ill));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_select"}, 64'(bus.select), 64'd0);
        chk({tag, "_result"}, 64'(bus.result), 64'd0);
        chk({tag, "_result_hi"}, 64'(bus.result_hi), 64'd0);
        chk({tag, "_zero"}, 64'(bus.zero), 64'd0);
        chk({tag, "_illegal"}, 64'(bus.illegal), 64'd0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(3))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom);
            default: return W'($urandom_range(15));
        endcase
    endfunction

    initial begin
        int n;
        drive(1'b0, 2'b00, 6'd0, '0, '0, 1'b1);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1 chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // add 5+7
        @(negedge clk);
        drive(1'b1, 2'b00, 6'd0, 32'd5, 32'd7, 1'b1);
        tick();
        chk("t1_result", 64'(bus.result), 64'd12);
        chk("t1_select", 64'(bus.select), 64'b010);
        chk("t1_zero", 64'(bus.zero), 64'd0);

        // R-type ops back to back on 0xF0 / -1
        drive(1'b1, 2'b10, 6'b100010, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1); tick();
        chk("t2_sub", 64'(bus.result), 64'h0000_00F1);
        chk("t2_sub_sel", 64'(bus.select), 64'b110);
        drive(1'b1, 2'b10, 6'b100100, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1); tick();
        chk("t2_and", 64'(bus.result), 64'h0000_00F0);
        drive(1'b1, 2'b10, 6'b100101, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1); tick();
        chk("t2_or", 64'(bus.result), 64'hFFFF_FFFF);
        chk("t2_or_sel", 64'(bus.select), 64'b001);
        drive(1'b1, 2'b10, 6'b101010, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1); tick();
        chk("t2_slt", 64'(bus.result), 64'd0);
        chk("t2_slt_sel", 64'(bus.select), 64'b111);
        drive(1'b1, 2'b10, 6'b100111, 32'h0000_00F0, 32'hFFFF_FFFF, 1'b1); tick();
        chk("t2_nor", 64'(bus.result), 64'd0);
        chk("t2_nor_zero", 64'(bus.zero), 64'd1);

        // multu 0xFFFFFFFF * 2, junk requests offered while busy
        drive(1'b1, 2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, 1'b1); tick();
        n = 1;
        chk("t3_busy", 64'(bus.busy), 64'd1);
        chk("t3_in_ready", 64'(bus.in_ready), 64'd0);
        while (!bus.out_valid && n < 40) begin
            drive(1'b1, 2'b00, 6'd0, pick(), pick(), 1'b1);
            tick();
            n++;
        end
        chk("t3_latency", 64'(n), 64'd33);
        chk("t3_hi", 64'(bus.result_hi), 64'd1);
        chk("t3_lo", 64'(bus.result), 64'hFFFF_FFFE);
        chk("t3_sel", 64'(bus.select), 64'b011);

        // hold under backpressure, then consume + accept on the same edge
        drive(1'b0, 2'b00, 6'd0, '0, '0, 1'b1); tick();
        drive(1'b1, 2'b00, 6'd0, 32'd1, 32'd1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 6'd0, 32'd3, 32'd4, 1'b0); tick();
            chk("t4_hold", 64'(bus.result), 64'd2);
            chk("t4_in_ready", 64'(bus.in_ready), 64'd0);
        end
        drive(1'b1, 2'b00, 6'd0, 32'd3, 32'd4, 1'b1); tick();
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_new", 64'(bus.result), 64'd7);

        // illegal encodings
        drive(1'b1, 2'b11, 6'b100000, 32'd9, 32'd9, 1'b1); tick();
        chk("t5_ill", 64'(bus.illegal), 64'd1);
        chk("t5_sel", 64'(bus.select), 64'b101);
        drive(1'b1, 2'b10, 6'b000000, 32'd9, 32'd9, 1'b1); tick();
        chk("t5_ill_fn", 64'(bus.illegal), 64'd1);
        chk("t5_res", 64'(bus.result), 64'd0);

        // reset in the middle of a multiply
        drive(1'b1, 2'b10, 6'b011001, 32'd1234, 32'd5678, 1'b1); tick();
        drive(1'b0, 2'b00, 6'd0, '0, '0, 1'b1);
        repeat (9) tick();
        rst_n = 1'b0;
        #1 chk_reset_outputs("t6");
        m_valid = 1'b0; m_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t6_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 2'b00, 6'd0, 32'd2, 32'd2, 1'b1); tick();
        chk("t6_add", 64'(bus.result), 64'd4);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(3) != 0, 2'($urandom_range(3)), fn_tab[$urandom_range(8)],
                  pick(), pick(), $urandom_range(3) != 0);
            tick();
        end
        drive(1'b0, 2'b00, 6'd0, '0, '0, 1'b1);
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
